modn_pulse_gen: RTL
===================

Name: modn_pulse_gen

Overview:
- Parametrised successor to the fixed divide-by-10 pulse counter.
- Generates a one-cycle pulse every N enabled clock cycles. N is programmable at runtime.
- Supports two modes:
  - periodic: free-running divider.
  - one-shot: a start request produces exactly one delayed pulse.
- Adds pause (enable), synchronous clear, and optional retrigger. Used as the common tick/timeout source for timing logic in the design.

Parameters:
- WIDTH, 8, width of the counter and of the divisor input.
- RETRIGGER, 0, one-shot mode only. 1 = a start while running restarts the period; 0 = the start is ignored.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-low reset.
- en, input, 1, count enable. Low pauses the counter (holds state).
- clr, input, 1, synchronous clear; highest priority after reset.
- mode, input, 1, 0 = periodic, 1 = one-shot. Sampled only at a period start.
- start, input, 1, one-shot trigger. Qualified by en.
- div, input, WIDTH, period length N in cycles. Values 0 and 1 both mean period 1. Sampled only at a period start.
- count, output, WIDTH, current position in the period, 0..N-1.
- pulse, output, 1, registered terminal pulse, high for one cycle per completed period.
- busy, output, 1, high while the state is RUN.

Behaviour:
- Reset (rst low, asynchronous, no clock needed):
  - state=IDLE, count=0, pulse=0, busy=0, div_q=1, mode_q=0.
  - Release is synchronous to the next edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- div_q = (div==0 ? 1 : div). div_q and mode_q are latched only on IDLE->RUN, at each wrap that stays in RUN, and on a retrigger.
  - Changing div or mode mid-period never affects the current period.
- Priority at each edge: clr > en=0 > normal operation.
  - clr=1: state=IDLE, count=0, pulse=0. div_q and mode_q are unchanged. clr wins over a simultaneous start or wrap.
- en=0 (no clr): count, state, div_q and mode_q are held; pulse=0. A start with en=0 is ignored.
- IDLE, en=1:
  - Moves to RUN (latching div_q and mode_q) if mode=0, or if mode=1 and start=1.
  - count stays 0 on the entry edge; pulse=0.
- RUN, en=1, count != div_q-1: count increments by 1; pulse=0.
- RUN, en=1, count == div_q-1 (wrap):
  - count=0, pulse=1.
  - If mode_q=1, go to IDLE.
  - Otherwise stay in RUN and re-latch div_q and mode_q from the inputs.
  - A periodic run switched to mode=1 therefore completes one more (one-shot) period and then idles.
- Latency: pulse is high in the cycle after the N-th enabled edge following RUN entry.
  - Periodic N=1 gives pulse constantly high.
  - Periodic N=10 gives the pattern 1 high, 9 low.
- Retrigger (RUN, mode_q=1, start=1, en=1), RETRIGGER=1:
  - count=0; div_q and mode_q re-latched; stay in RUN.
  - If the same edge is a wrap, pulse=1 is still emitted and the block stays in RUN.
  - With RETRIGGER=0 a start in RUN is ignored.
- Counter arithmetic is WIDTH bits. count can never exceed div_q-1, so no overflow is possible. The maximum period is 2^WIDTH-1.
- busy is high from the RUN-entry edge until the wrap edge that returns to IDLE.

Test Plan:
1. Async reset: assert rst low between clock edges mid-run -> count=0, pulse=0, busy=0 immediately. After release with mode=0, en=1, div=10 -> first pulse 10 cycles after the RUN-entry edge.
2. Periodic: div=10, en=1 for 50 cycles -> count cycles 0..9, pulse high exactly 1 cycle in every 10, five pulses total.
3. Degenerate divisors: div=1, then div=0 (each applied from IDLE after clr) -> pulse continuously high, count stays 0.
4. One-shot: mode=1, div=5, single-cycle start -> busy high for 5 cycles, exactly one pulse, then IDLE. A second start 2 cycles later: RETRIGGER=0 gives no change; RETRIGGER=1 moves the pulse 2 cycles later.
5. Pause: periodic div=10, en low for 3 cycles at count=4 -> count holds 4 and the next pulse is delayed by exactly 3 cycles.
6. Config change and clear: change div 10->4 at count=6 -> current period still ends at 10, following periods are 4. Assert clr together with start -> IDLE, count=0, no pulse.

Source files
------------

// File: rtl/modn_pulse_gen.sv
// Programmable modulo-N tick generator: periodic divider or delayed one-shot,
// with pause, synchronous clear and optional one-shot retrigger.
module modn_pulse_gen #(
    parameter int WIDTH     = 8,
    parameter bit RETRIGGER = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             mode,
    input  logic             start,
    input  logic [WIDTH-1:0] div,
    output logic [WIDTH-1:0] count,
    output logic             pulse,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] count_n;
    logic [WIDTH-1:0] div_q, div_q_n;
    logic             mode_q, mode_q_n;
    logic             pulse_n;

    logic [WIDTH-1:0] div_eff;
    logic             wrap;
    logic             retrig;

    // A divisor of 0 is treated as 1 so the wrap compare below never underflows.
    assign div_eff = (div == '0) ? WIDTH'(1) : div;
    assign wrap    = (count == div_q - WIDTH'(1));
    assign retrig  = RETRIGGER && mode_q && start;

    // NOTE: every next-state variable gets its hold value first so no path through
    // the case tree leaves one unassigned, which would infer a latch.
    always_comb begin
        state_n  = state;
        count_n  = count;
        div_q_n  = div_q;
        mode_q_n = mode_q;
        pulse_n  = 1'b0;

        if (clr) begin
            state_n = IDLE;
            count_n = '0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (!mode || start) begin
                        state_n  = RUN;
                        div_q_n  = div_eff;
                        mode_q_n = mode;
                    end
                end
                RUN: begin
                    if (wrap) begin
                        count_n = '0;
                        pulse_n = 1'b1;
                        if (mode_q && !retrig) begin
                            state_n = IDLE;
                        end else begin
                            div_q_n  = div_eff;
                            mode_q_n = mode;
                        end
                    end else if (retrig) begin
                        count_n  = '0;
                        div_q_n  = div_eff;
                        mode_q_n = mode;
                    end else begin
                        count_n = count + WIDTH'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update
    // together from values sampled before the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            count  <= '0;
            pulse  <= 1'b0;
            div_q  <= WIDTH'(1);
            mode_q <= 1'b0;
        end else begin
            state  <= state_n;
            count  <= count_n;
            pulse  <= pulse_n;
            div_q  <= div_q_n;
            mode_q <= mode_q_n;
        end
    end

    assign busy = (state == RUN);

endmodule
